// File: rtl/tile_ctrl_pkg.sv
// Shared definitions for the tile fetch controller: FSM state encoding and
// default loop/address widths.
package tile_ctrl_pkg;

  localparam int CW_DEF = 16;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tile_state_t;

endpackage

// File: rtl/tile_loop_cnt3.sv
// Three-level nested loop index counter (cnt0 innermost) with runtime extents.
// Exposes the wrap carries so the owner can update its address pointers.
module tile_loop_cnt3
  import tile_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [CW-1:0] n0,
  input  logic [CW-1:0] n1,
  input  logic [CW-1:0] n2,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic          wrap0,
  output logic          wrap1,
  output logic          last
);

  logic max0, max1, max2;

  assign max0  = (cnt0 == n0 - CW'(1));
  assign max1  = (cnt1 == n1 - CW'(1));
  assign max2  = (cnt2 == n2 - CW'(1));
  assign wrap0 = step && max0;
  assign wrap1 = wrap0 && max1;
  assign last  = max0 && max1 && max2;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (step) begin
      cnt0 <= max0 ? '0 : cnt0 + CW'(1);
      if (max0) cnt1 <= max1 ? '0 : cnt1 + CW'(1);
      if (max0 && max1) cnt2 <= max2 ? '0 : cnt2 + CW'(1);
    end
  end

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Tile read sequencer: walks n2 x n1 x n0 elements, issues one address request each,
// caps in-flight reads and pulses done once every response is back.
// Optional perf counters (stall_cycles, tile_cycles) when TILE_FETCH_PERF_EN is defined.
module tile_fetch_ctrl
  import tile_ctrl_pkg::*;
#(
  parameter int CW        = CW_DEF,
  parameter int AW        = AW_DEF,
  parameter int MAX_OUTST = 8,
  parameter int OW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] n0,
  input  logic [CW-1:0] n1,
  input  logic [CW-1:0] n2,
  input  logic [AW-1:0] stride1,
  input  logic [AW-1:0] stride2,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  output logic          req_last,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  input  logic          rsp_valid,
  output logic          busy,
`ifdef TILE_FETCH_PERF_EN
  output logic [31:0]   stall_cycles,
  output logic [31:0]   tile_cycles,
`endif
  output logic          done
);

  tile_state_t   state;
  logic [CW-1:0] n0_q, n1_q, n2_q;
  logic [AW-1:0] s1_q, s2_q, row_ptr, plane_ptr, row_nxt, plane_nxt;
  logic [OW-1:0] outstanding;
  logic          hs, rsp_take, wrap0, wrap1, last_idx;
  logic          accept_start, any_zero, drain_empty;

  assign req_valid    = (state == ST_RUN) && (outstanding < OW'(MAX_OUTST));
  assign hs           = req_valid && req_ready;
  assign rsp_take     = rsp_valid && (outstanding != '0);
  assign req_last     = (state == ST_RUN) && last_idx;
  assign accept_start = (state == ST_IDLE) && start;
  assign any_zero     = (n0 == '0) || (n1 == '0) || (n2 == '0);
  // A response landing in the same cycle as the final check still counts as drained.
  assign drain_empty  = (outstanding == '0) || ((outstanding == OW'(1)) && rsp_valid);
  assign row_nxt      = row_ptr + s1_q;
  assign plane_nxt    = plane_ptr + s2_q;

  tile_loop_cnt3 #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_start),
    .step  (hs),
    .n0    (n0_q),
    .n1    (n1_q),
    .n2    (n2_q),
    .cnt0  (cnt0),
    .cnt1  (cnt1),
    .cnt2  (cnt2),
    .wrap0 (wrap0),
    .wrap1 (wrap1),
    .last  (last_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_addr  <= '0;
      row_ptr   <= '0;
      plane_ptr <= '0;
      n0_q      <= '0;
      n1_q      <= '0;
      n2_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          n0_q      <= n0;
          n1_q      <= n1;
          n2_q      <= n2;
          s1_q      <= stride1;
          s2_q      <= stride2;
          req_addr  <= base_addr;
          row_ptr   <= base_addr;
          plane_ptr <= base_addr;
          busy      <= 1'b1;
          if (any_zero) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: if (hs) begin
          // Pointer walk replaces cnt*stride multiplies.
          if (wrap1) begin
            plane_ptr <= plane_nxt;
            row_ptr   <= plane_nxt;
            req_addr  <= plane_nxt;
          end else if (wrap0) begin
            row_ptr  <= row_nxt;
            req_addr <= row_nxt;
          end else begin
            req_addr <= req_addr + AW'(1);
          end
          if (last_idx) state <= ST_DRAIN;
        end
        ST_DRAIN: if (drain_empty) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (hs && !rsp_take) begin
      outstanding <= outstanding + OW'(1);
    end else if (!hs && rsp_take) begin
      outstanding <= outstanding - OW'(1);
    end
  end

`ifdef TILE_FETCH_PERF_EN
  logic outst_full;
  assign outst_full = (outstanding == OW'(MAX_OUTST));

  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      stall_cycles <= '0;
      tile_cycles  <= '0;
    end else begin
      if (busy) tile_cycles <= tile_cycles + 32'd1;
      if ((state == ST_RUN) && ((req_valid && !req_ready) || outst_full))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Self-checking bench for tile_fetch_ctrl: nested-loop address model, response
// latency queue and outstanding-cap expectation, with randomized ready/latency.
module tb_tile_fetch_ctrl;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst, start, req_ready, rsp_valid;
  logic [31:0] base_addr, stride1, stride2;
  logic [15:0] n0, n1, n2;
  logic        req_valid, req_last, busy, done;
  logic [31:0] req_addr;
  logic [15:0] cnt0, cnt1, cnt2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] c2;
    logic        last;
  } req_t;

  req_t exp_q[$];

  always #5 clk = ~clk;

  tile_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .n0        (n0),
    .n1        (n1),
    .n2        (n2),
    .stride1   (stride1),
    .stride2   (stride2),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .rsp_valid (rsp_valid),
    .busy      (busy),
    .done      (done)
  );

  // Expected request stream straight from the nested-loop definition.
  task automatic build_exp(input int d0, input int d1, input int d2,
                           input logic [31:0] b, input logic [31:0] s1, input logic [31:0] s2);
    req_t r;
    exp_q.delete();
    for (int i2 = 0; i2 < d2; i2++)
      for (int i1 = 0; i1 < d1; i1++)
        for (int i0 = 0; i0 < d0; i0++) begin
          r.addr = b + 32'(i0) + 32'(i1) * s1 + 32'(i2) * s2;
          r.c0   = 16'(i0);
          r.c1   = 16'(i1);
          r.c2   = 16'(i2);
          r.last = (i0 == d0 - 1) && (i1 == d1 - 1) && (i2 == d2 - 1);
          exp_q.push_back(r);
        end
  endtask

  task automatic check_idle_outputs(input string nm);
    tests++;
    if (req_valid !== 1'b0 || req_addr !== 32'd0 || req_last !== 1'b0 || cnt0 !== 16'd0 ||
        cnt1 !== 16'd0 || cnt2 !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s: got valid=%b addr=%h last=%b cnt=%0d/%0d/%0d busy=%b done=%b, want all 0",
               nm, req_valid, req_addr, req_last, cnt0, cnt1, cnt2, busy, done);
    end
  endtask

  task automatic run_tile(input string nm, input int d0, input int d1, input int d2,
                          input logic [31:0] b, input logic [31:0] s1, input logic [31:0] s2,
                          input int ready_pct, input int lat, input int hold_until,
                          input bit glitch, input int abort_after);
    int          due_q[$];
    int          cyc = 0, nreq = 0, nrsp = 0, last_rsp = -1, total;
    bit          exp_done, exp_valid, fin = 0, prev_stall = 0, aborted = 0;
    logic [31:0] prev_addr;
    logic [15:0] p0, p1, p2;
    req_t        e;

    build_exp(d0, d1, d2, b, s1, s2);
    total = exp_q.size();
    @(negedge clk);
    n0 = 16'(d0); n1 = 16'(d1); n2 = 16'(d2);
    base_addr = b; stride1 = s1; stride2 = s2;
    req_ready = 1'b0; rsp_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    while (!fin) begin
      if (cyc >= 3000) begin
        tests++; fails++;
        $display("FAIL %s timeout: got no done after %0d cycles, want done", nm, cyc);
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        return;
      end
      exp_done  = (total == 0) ? (cyc == 0) : (nrsp == total && cyc == last_rsp + 1);
      exp_valid = (nreq < total) && ((nreq - nrsp) < MAXO);
      tests++;
      if (done !== exp_done) begin
        fails++; $display("FAIL %s done @%0d: got %b want %b", nm, cyc, done, exp_done);
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL %s busy @%0d: got %b want 1", nm, cyc, busy);
      end
      tests++;
      if (req_valid !== exp_valid) begin
        fails++; $display("FAIL %s req_valid @%0d: got %b want %b", nm, cyc, req_valid, exp_valid);
      end
      if (req_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q[0];
        tests++;
        if (req_addr !== e.addr || cnt0 !== e.c0 || cnt1 !== e.c1 || cnt2 !== e.c2 || req_last !== e.last) begin
          fails++;
          $display("FAIL %s req #%0d: got addr=%h cnt=%0d/%0d/%0d last=%b want addr=%h cnt=%0d/%0d/%0d last=%b",
                   nm, nreq, req_addr, cnt0, cnt1, cnt2, req_last, e.addr, e.c0, e.c1, e.c2, e.last);
        end
        if (prev_stall) begin
          tests++;
          if (req_addr !== prev_addr || cnt0 !== p0 || cnt1 !== p1 || cnt2 !== p2) begin
            fails++;
            $display("FAIL %s stable @%0d: got addr=%h want %h", nm, cyc, req_addr, prev_addr);
          end
        end
      end
      if (hold_until > 0 && cyc == hold_until) begin
        tests++;
        if (nreq != MAXO) begin
          fails++; $display("FAIL %s outstanding cap: got %0d handshakes want %0d", nm, nreq, MAXO);
        end
      end

      if (done === 1'b1) begin
        fin = 1;
        start = glitch;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end else begin
        req_ready = ($urandom_range(99, 0) < ready_pct);
        rsp_valid = (due_q.size() > 0 && due_q[0] <= cyc && cyc >= hold_until);
        if (rsp_valid) begin
          void'(due_q.pop_front());
          nrsp++;
          last_rsp = cyc;
        end
        start = glitch && (cyc % 2 == 1);
        prev_stall = req_valid && !req_ready;
        prev_addr = req_addr; p0 = cnt0; p1 = cnt1; p2 = cnt2;
        if (req_valid === 1'b1 && req_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          due_q.push_back(cyc + lat);
          nreq++;
          if (abort_after > 0 && nreq == abort_after) begin
            rst = 1'b1;
            aborted = 1;
          end
        end
      end
      @(negedge clk);
      cyc++;

      if (aborted) begin
        check_idle_outputs({nm, " abort"});
        rst = 1'b0; start = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_idle_outputs({nm, " late rsp"});
        return;
      end
    end

    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || req_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after done: got busy=%b done=%b valid=%b want 0/0/0", nm, busy, done, req_valid);
    end
    tests++;
    if (nreq != total) begin
      fails++; $display("FAIL %s req count: got %0d want %0d", nm, nreq, total);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    base_addr = '0; stride1 = '0; stride2 = '0; n0 = '0; n1 = '0; n2 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset released");
  endtask

  task automatic test_basic();
    run_tile("basic", 4, 2, 2, 32'h100, 32'h10, 32'h100, 100, 2, 0, 0, 0);
  endtask

  task automatic test_ready_toggle();
    run_tile("ready50", 4, 2, 2, 32'h100, 32'h10, 32'h100, 50, 2, 0, 0, 0);
  endtask

  task automatic test_outstanding_cap();
    run_tile("cap", 4, 2, 2, 32'h100, 32'h10, 32'h100, 100, 1, 20, 0, 0);
  endtask

  task automatic test_zero_dim();
    run_tile("n1_zero", 4, 0, 2, 32'h100, 32'h10, 32'h100, 100, 2, 0, 0, 0);
    run_tile("n0_zero", 0, 3, 3, 32'h40, 32'h8, 32'h80, 100, 2, 0, 0, 0);
    run_tile("n2_zero", 2, 2, 0, 32'h40, 32'h8, 32'h80, 100, 2, 0, 0, 0);
  endtask

  task automatic test_single();
    run_tile("single", 1, 1, 1, 32'hABC0, 32'h10, 32'h100, 100, 3, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    run_tile("start_ign", 4, 2, 2, 32'h100, 32'h10, 32'h100, 70, 3, 0, 1, 0);
  endtask

  task automatic test_rst_mid();
    run_tile("abort", 4, 2, 2, 32'h100, 32'h10, 32'h100, 100, 4, 0, 0, 5);
    run_tile("after_abort", 4, 2, 2, 32'h100, 32'h10, 32'h100, 100, 2, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_tile("random", int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
               $urandom(), $urandom_range(255, 0), $urandom(),
               int'($urandom_range(100, 30)), int'($urandom_range(6, 1)), 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_outstanding_cap();
    test_zero_dim();
    test_single();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
